ibex_ccu_issuer: RTL and testbench
==================================

# ibex_ccu_issuer

Core-side initiator for the custom compute unit (CCU) command/response interface. Accepts one CCU instruction at a time from the Ibex execute stage, drives the CCU with a single-cycle enable and stable payload, and waits for the CCU response. Returns the result, or a timeout error, to the core with a one-cycle valid pulse. Sits between the ID/EX stage and `ibex_ccu`, and supplies the stall signal that holds the pipeline while a CCU operation is outstanding.

## Interface
- TIMEOUT_CYCLES, 16: maximum WAIT cycles before the operation is aborted; legal range 1..255.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  core presents a CCU instruction.
- req_ready_o  out  1  issuer can accept; high only in IDLE.
- req_function_id_i  in  10  CCU function id.
- req_operand_a_i  in  32  first operand.
- req_operand_b_i  in  32  second operand.
- result_valid_o  out  1  one-cycle pulse; result/error valid.
- result_o  out  32  CCU output, or 0 on timeout.
- result_err_o  out  1  qualifies result_valid_o; 1 = timeout.
- busy_o  out  1  operation outstanding (stall request); high in ISSUE, WAIT, DONE.
- ccu_en_o  out  1  CCU enable, one cycle per operation.
- ccu_function_id_o  out  10  to CCU cmd_payload_function_id.
- ccu_inputs_0_o  out  32  to CCU cmd_payload_inputs_0.
- ccu_inputs_1_o  out  32  to CCU cmd_payload_inputs_1.
- ccu_rsp_valid_i  in  1  CCU response valid.
- ccu_rsp_outputs_0_i  in  32  CCU response data.
- op_count_o  out  16  completed operations, successful and timed out; wraps at 0xFFFF to 0.
- stray_rsp_o  out  1  sticky; set when ccu_rsp_valid_i is high outside WAIT; cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: req_ready_o=1. When req_valid_i=1, latch function id and both operands into payload registers and go to ISSUE.
- ISSUE: ccu_en_o=1 for exactly this cycle, then go to WAIT. Clear the timeout counter.
- WAIT: ccu_en_o=0 and the payload is held stable.
  - If ccu_rsp_valid_i=1: capture ccu_rsp_outputs_0_i into the result register, set err=0, go to DONE.
  - Otherwise, if the counter equals TIMEOUT_CYCLES-1: set result=0 and err=1, go to DONE.
  - Otherwise: increment the counter.
  - If response and timeout occur in the same cycle, the response wins (err=0).
- DONE: result_valid_o=1 for one cycle, op_count_o increments, go to IDLE. The core must consume the result in that cycle; there is no backpressure.
- ccu_function_id_o and ccu_inputs_*_o always reflect the payload registers. They change only on acceptance in IDLE.
- result_o and result_err_o hold their last value after DONE until the next DONE.
- stray_rsp_o sets on ccu_rsp_valid_i=1 in IDLE, ISSUE, or DONE. A stray response never alters the result or the state.
- Counter width is 8 bits, which covers the full TIMEOUT_CYCLES range.

## Timing
- Reset (async assert, clk-synchronous deassert): state=IDLE.
  - Outputs: req_ready_o=1, busy_o=0, ccu_en_o=0, result_valid_o=0, result_err_o=0, stray_rsp_o=0.
  - Cleared to 0: result_o, ccu_function_id_o, ccu_inputs_*_o, op_count_o.
- Reset in any state aborts the operation immediately. No result_valid_o pulse is produced and op_count_o is not incremented.
- Acceptance at edge N gives:
  - ISSUE during cycle N+1 (ccu_en_o=1);
  - WAIT from N+2.
- With the standard CCU (response one cycle after enable):
  - response seen in the first WAIT cycle, N+2;
  - result_valid_o in cycle N+3;
  - req_ready_o high again in N+4.
- Back-to-back throughput: one operation per 4 cycles.
- Timeout: first WAIT cycle N+2, last WAIT cycle N+1+TIMEOUT_CYCLES, result_valid_o with err=1 in the following cycle.
- req_valid_i is ignored outside IDLE; the core holds its request until req_ready_o=1.

## Test plan
- Reset, then req fid=0x000, a=0x01020304, b=0x01010101; CCU model responds 0x00000206 one cycle after enable.
  - Required: ccu_en_o pulses exactly once; result_valid_o pulses 3 cycles after acceptance with result_o=0x206, err=0; op_count_o=1.
- CCU model never responds, TIMEOUT_CYCLES=16.
  - Required: result_valid_o arrives 18 cycles after acceptance with result_o=0, err=1; busy_o high throughout; op_count_o increments.
- Response and counter=TIMEOUT_CYCLES-1 in the same cycle, response data 0xDEADBEEF.
  - Required: result_o=0xDEADBEEF, err=0.
- req_valid_i held high for 3 operations.
  - Required: accepts at cycles 0, 4, 8; payload changes only at accept edges; op_count_o=3.
- ccu_rsp_valid_i pulsed while IDLE.
  - Required: stray_rsp_o=1 and stays set; no result_valid_o; next operation completes normally.
- Assert reset during WAIT.
  - Required: all outputs return to reset values in the same cycle; no result_valid_o pulse; op_count_o=0.

Source files
------------

// File: rtl/ibex_ccu_issuer.sv
// Core-side CCU command issuer: accepts one instruction at a time, fires a
// single-cycle CCU enable, and returns the response or a timeout to the core.
module ibex_ccu_issuer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [9:0]  req_function_id_i,
    input  logic [31:0] req_operand_a_i,
    input  logic [31:0] req_operand_b_i,
    output logic        result_valid_o,
    output logic [31:0] result_o,
    output logic        result_err_o,
    output logic        busy_o,
    output logic        ccu_en_o,
    output logic [9:0]  ccu_function_id_o,
    output logic [31:0] ccu_inputs_0_o,
    output logic [31:0] ccu_inputs_1_o,
    input  logic        ccu_rsp_valid_i,
    input  logic [31:0] ccu_rsp_outputs_0_i,
    output logic [15:0] op_count_o,
    output logic        stray_rsp_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [9:0]  fid_q, fid_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic        err_q, err_d;
    logic [15:0] op_count_q, op_count_d;
    logic        stray_q, stray_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fid_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            op_count_q <= '0;
            stray_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fid_q      <= fid_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            err_q      <= err_d;
            op_count_q <= op_count_d;
            stray_q    <= stray_d;
        end
    end

    // A response only means something in WAIT; anywhere else it is flagged and otherwise dropped.
    always_comb begin
        state_d    = state_q;
        fid_d      = fid_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        err_d      = err_q;
        op_count_d = op_count_q;
        stray_d    = stray_q | (ccu_rsp_valid_i & (state_q != WAIT));

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    fid_d   = req_function_id_i;
                    opa_d   = req_operand_a_i;
                    opb_d   = req_operand_b_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (ccu_rsp_valid_i) begin
                    result_d = ccu_rsp_outputs_0_i;
                    err_d    = 1'b0;
                    state_d  = DONE;
                end else if (cnt_q == TimeoutLast) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                op_count_d = op_count_q + 16'd1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o       = (state_q == IDLE);
    assign busy_o            = (state_q != IDLE);
    assign ccu_en_o          = (state_q == ISSUE);
    assign result_valid_o    = (state_q == DONE);
    assign result_o          = result_q;
    assign result_err_o      = err_q;
    assign ccu_function_id_o = fid_q;
    assign ccu_inputs_0_o    = opa_q;
    assign ccu_inputs_1_o    = opb_q;
    assign op_count_o        = op_count_q;
    assign stray_rsp_o       = stray_q;

endmodule

// File: tb/tb_ibex_ccu_issuer.sv
// Directed bench for ibex_ccu_issuer: standard response, timeout, response/timeout
// race, held request throughput, stray response and reset during WAIT.
module tb_ibex_ccu_issuer;

    logic        clk;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [9:0]  reqFid;
    logic [31:0] reqOpA;
    logic [31:0] reqOpB;
    logic        resultValid;
    logic [31:0] result;
    logic        resultErr;
    logic        busy;
    logic        ccuEn;
    logic [9:0]  ccuFid;
    logic [31:0] ccuIn0;
    logic [31:0] ccuIn1;
    logic        rspValid;
    logic [31:0] rspData;
    logic [15:0] opCount;
    logic        strayRsp;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int acceptCyc [3];

    logic [9:0]  fidTab  [3] = '{10'h011, 10'h022, 10'h033};
    logic [31:0] opATab  [3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    logic [31:0] opBTab  [3] = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
    logic [31:0] rspTab  [3] = '{32'h0000_1000, 32'h0000_2001, 32'h0000_3002};

    ibex_ccu_issuer #(.TIMEOUT_CYCLES(16)) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid_i         (reqValid),
        .req_ready_o         (reqReady),
        .req_function_id_i   (reqFid),
        .req_operand_a_i     (reqOpA),
        .req_operand_b_i     (reqOpB),
        .result_valid_o      (resultValid),
        .result_o            (result),
        .result_err_o        (resultErr),
        .busy_o              (busy),
        .ccu_en_o            (ccuEn),
        .ccu_function_id_o   (ccuFid),
        .ccu_inputs_0_o      (ccuIn0),
        .ccu_inputs_1_o      (ccuIn1),
        .ccu_rsp_valid_i     (rspValid),
        .ccu_rsp_outputs_0_i (rspData),
        .op_count_o          (opCount),
        .stray_rsp_o         (strayRsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b);
        reqValid = valid;
        reqFid   = fid;
        reqOpA   = a;
        reqOpB   = b;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".ready"}, 32'(reqReady), 32'd1);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".en"}, 32'(ccuEn), 32'd0);
        checkOutput({tag, ".rvalid"}, 32'(resultValid), 32'd0);
        checkOutput({tag, ".err"}, 32'(resultErr), 32'd0);
        checkOutput({tag, ".stray"}, 32'(strayRsp), 32'd0);
        checkOutput({tag, ".result"}, result, 32'd0);
        checkOutput({tag, ".fid"}, 32'(ccuFid), 32'd0);
        checkOutput({tag, ".in0"}, ccuIn0, 32'd0);
        checkOutput({tag, ".in1"}, ccuIn1, 32'd0);
        checkOutput({tag, ".opcount"}, 32'(opCount), 32'd0);
    endtask

    // Standard CCU: response presented in the first WAIT cycle, one cycle after the enable.
    task automatic runStdOp(input string tag, input logic [9:0] fid, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] rsp, input logic [15:0] expCount);
        applyStimulus(1'b1, fid, a, b);
        tick();
        applyStimulus(1'b0, 10'h000, 32'h0, 32'h0);
        checkOutput({tag, ".issue.en"}, 32'(ccuEn), 32'd1);
        checkOutput({tag, ".issue.busy"}, 32'(busy), 32'd1);
        checkOutput({tag, ".issue.ready"}, 32'(reqReady), 32'd0);
        checkOutput({tag, ".fid"}, 32'(ccuFid), 32'(fid));
        checkOutput({tag, ".in0"}, ccuIn0, a);
        checkOutput({tag, ".in1"}, ccuIn1, b);
        tick();
        checkOutput({tag, ".wait.en"}, 32'(ccuEn), 32'd0);
        checkOutput({tag, ".wait.rvalid"}, 32'(resultValid), 32'd0);
        rspValid = 1'b1;
        rspData  = rsp;
        tick();
        rspValid = 1'b0;
        rspData  = 32'h0;
        checkOutput({tag, ".done.rvalid"}, 32'(resultValid), 32'd1);
        checkOutput({tag, ".done.en"}, 32'(ccuEn), 32'd0);
        checkOutput({tag, ".done.result"}, result, rsp);
        checkOutput({tag, ".done.err"}, 32'(resultErr), 32'd0);
        tick();
        checkOutput({tag, ".idle.rvalid"}, 32'(resultValid), 32'd0);
        checkOutput({tag, ".idle.ready"}, 32'(reqReady), 32'd1);
        checkOutput({tag, ".idle.opcount"}, 32'(opCount), 32'(expCount));
        checkOutput({tag, ".idle.result_hold"}, result, rsp);
    endtask

    initial begin
        reset    = 1'b1;
        rspValid = 1'b0;
        rspData  = 32'h0;
        applyStimulus(1'b0, 10'h000, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        checkResetOutputs("reset");

        $display("[TB] standard operation");
        runStdOp("std", 10'h000, 32'h0102_0304, 32'h0101_0101, 32'h0000_0206, 16'd1);

        $display("[TB] timeout");
        applyStimulus(1'b1, 10'h3FF, 32'h5555_5555, 32'hAAAA_AAAA);
        tick();
        applyStimulus(1'b0, 10'h000, 32'h0, 32'h0);
        for (int i = 2; i <= 17; i++) begin
            tick();
            checkOutput($sformatf("tmo.busy@%0d", i), 32'(busy), 32'd1);
            checkOutput($sformatf("tmo.rvalid@%0d", i), 32'(resultValid), 32'd0);
        end
        tick();
        checkOutput("tmo.done.rvalid", 32'(resultValid), 32'd1);
        checkOutput("tmo.done.busy", 32'(busy), 32'd1);
        checkOutput("tmo.done.result", result, 32'd0);
        checkOutput("tmo.done.err", 32'(resultErr), 32'd1);
        tick();
        checkOutput("tmo.idle.opcount", 32'(opCount), 32'd2);
        checkOutput("tmo.idle.err_hold", 32'(resultErr), 32'd1);
        checkOutput("tmo.idle.ready", 32'(reqReady), 32'd1);

        $display("[TB] response and timeout in the same cycle");
        applyStimulus(1'b1, 10'h155, 32'h0000_0007, 32'h0000_0009);
        tick();
        applyStimulus(1'b0, 10'h000, 32'h0, 32'h0);
        for (int i = 2; i <= 17; i++) tick();
        checkOutput("race.lastwait.rvalid", 32'(resultValid), 32'd0);
        rspValid = 1'b1;
        rspData  = 32'hDEAD_BEEF;
        tick();
        rspValid = 1'b0;
        rspData  = 32'h0;
        checkOutput("race.done.rvalid", 32'(resultValid), 32'd1);
        checkOutput("race.done.result", result, 32'hDEAD_BEEF);
        checkOutput("race.done.err", 32'(resultErr), 32'd0);
        tick();
        checkOutput("race.idle.opcount", 32'(opCount), 32'd3);
        checkOutput("race.stray", 32'(strayRsp), 32'd0);

        $display("[TB] back-to-back with request held high");
        resetDut();
        applyStimulus(1'b1, fidTab[0], opATab[0], opBTab[0]);
        for (int k = 0; k < 3; k++) begin
            tick();
            acceptCyc[k] = cyc - 1;
            checkOutput($sformatf("b2b%0d.en", k), 32'(ccuEn), 32'd1);
            checkOutput($sformatf("b2b%0d.fid", k), 32'(ccuFid), 32'(fidTab[k]));
            checkOutput($sformatf("b2b%0d.in0", k), ccuIn0, opATab[k]);
            applyStimulus(1'b1, 10'h3FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            tick();
            checkOutput($sformatf("b2b%0d.hold.fid", k), 32'(ccuFid), 32'(fidTab[k]));
            checkOutput($sformatf("b2b%0d.hold.in1", k), ccuIn1, opBTab[k]);
            checkOutput($sformatf("b2b%0d.wait.ready", k), 32'(reqReady), 32'd0);
            rspValid = 1'b1;
            rspData  = rspTab[k];
            tick();
            rspValid = 1'b0;
            rspData  = 32'h0;
            checkOutput($sformatf("b2b%0d.rvalid", k), 32'(resultValid), 32'd1);
            checkOutput($sformatf("b2b%0d.result", k), result, rspTab[k]);
            checkOutput($sformatf("b2b%0d.done.in0", k), ccuIn0, opATab[k]);
            if (k < 2) applyStimulus(1'b1, fidTab[k+1], opATab[k+1], opBTab[k+1]);
            else       applyStimulus(1'b0, 10'h000, 32'h0, 32'h0);
            tick();
            checkOutput($sformatf("b2b%0d.idle.ready", k), 32'(reqReady), 32'd1);
            checkOutput($sformatf("b2b%0d.idle.fid", k), 32'(ccuFid), 32'(fidTab[k]));
        end
        checkOutput("b2b.accept1", 32'(acceptCyc[1] - acceptCyc[0]), 32'd4);
        checkOutput("b2b.accept2", 32'(acceptCyc[2] - acceptCyc[0]), 32'd8);
        checkOutput("b2b.opcount", 32'(opCount), 32'd3);

        $display("[TB] stray response in IDLE");
        rspValid = 1'b1;
        rspData  = 32'h1234_5678;
        tick();
        rspValid = 1'b0;
        rspData  = 32'h0;
        checkOutput("stray.set", 32'(strayRsp), 32'd1);
        checkOutput("stray.rvalid", 32'(resultValid), 32'd0);
        checkOutput("stray.ready", 32'(reqReady), 32'd1);
        checkOutput("stray.result_hold", result, rspTab[2]);
        tick();
        checkOutput("stray.sticky", 32'(strayRsp), 32'd1);
        checkOutput("stray.opcount", 32'(opCount), 32'd3);
        runStdOp("afterstray", 10'h2A5, 32'hCAFE_0000, 32'h0000_BABE, 32'h0BAD_F00D, 16'd4);
        checkOutput("afterstray.sticky", 32'(strayRsp), 32'd1);

        $display("[TB] reset during WAIT");
        applyStimulus(1'b1, 10'h0F0, 32'h7777_7777, 32'h8888_8888);
        tick();
        applyStimulus(1'b0, 10'h000, 32'h0, 32'h0);
        tick();
        checkOutput("rstwait.busy_before", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkResetOutputs("rstwait");
        tick();
        reset = 1'b0;
        tick();
        checkOutput("rstwait.after.rvalid", 32'(resultValid), 32'd0);
        checkOutput("rstwait.after.opcount", 32'(opCount), 32'd0);
        checkOutput("rstwait.after.ready", 32'(reqReady), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
